// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int PC_W        = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Sequential PC step; wraps modulo 2^64.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of {pc, instr} pairs between the fetch unit and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [PC_W-1:0]    o_head_pc,
    output logic [INSTR_W-1:0] o_head_instr,
    output logic [CW-1:0]      o_count
);

    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= i_pc;
            r_instr_mem[r_wr_ptr] <= i_instr;
        end
    end

    // Head reads as zero when empty so reset and idle outputs are clean.
    assign o_head_pc    = (r_count != '0) ? r_pc_mem[r_rd_ptr]    : '0;
    assign o_head_instr = (r_count != '0) ? r_instr_mem[r_rd_ptr] : '0;
    assign o_count      = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues credit-limited imem requests and
// queues returned words for decode; redirects flush and drop stale responses.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output fetch_state_t       dbg_state
);

    // Handshakes: a transfer happens on a posedge where valid && ready are both 1;
    // valid never depends combinationally on ready, and imem responses cannot stall.

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_resp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   w_inflight_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [CW-1:0]   w_count;
    logic [PC_W-1:0] w_redirect_pc;
    logic            w_req_fire;
    logic            w_resp_drop;
    logic            w_resp_live;
    logic            w_push;
    logic            w_pop;

    assign w_redirect_pc = redirect_pc & ~PC_W'(3);

    // Credit: live requests plus queued words never exceed the queue size.
    assign imem_req_valid = (r_state == FETCH) &&
                            (({1'b0, r_inflight} + {1'b0, w_count}) < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
    assign w_resp_live = imem_resp_valid && (r_drop_cnt == '0);
    assign w_push      = w_resp_live && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;

    always_comb begin
        w_inflight_nxt = r_inflight;
        w_drop_nxt     = r_drop_cnt;
        if (w_resp_drop) w_drop_nxt = w_drop_nxt - CW'(1);
        if (redirect_valid) begin
            // Every live request, including one accepted now, becomes stale.
            w_drop_nxt     = w_drop_nxt + r_inflight + CW'(w_req_fire) - CW'(w_resp_live);
            w_inflight_nxt = '0;
        end else begin
            w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(w_resp_live);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   if (redirect_valid && (w_drop_nxt != '0)) w_state_nxt = DRAIN;
            DRAIN:   if (w_drop_nxt == '0) w_state_nxt = FETCH;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inflight_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (redirect_valid)  r_fetch_pc <= w_redirect_pc;
            else if (w_req_fire) r_fetch_pc <= next_pc(r_fetch_pc);
            if (redirect_valid)  r_resp_pc <= w_redirect_pc;
            else if (w_push)     r_resp_pc <= next_pc(r_resp_pc);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pc         (r_resp_pc),
        .i_instr      (imem_resp_data),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_head_pc    (instr_pc),
        .o_head_instr (instr),
        .o_count      (w_count)
    );

    assign instr_valid = (w_count != '0);
    assign dbg_state   = r_state;

endmodule
